multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter MEM_WAIT_MAX, default 8'd255, meaning the maximum number of cycles any memory state waits for mem_ready.
REQ-002 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 SHALL have port resetn, input, 1, the asynchronous active-low reset.
REQ-004 SHALL have port op, input, 6, the opcode instr[31:26] taken from the instruction register.
REQ-005 SHALL have port mem_ready, input, 1, the unified memory completion strobe.
REQ-006 SHALL have port mem_req, output, 1, the memory access request.
REQ-007 SHALL have outputs IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, Branch and PCWrite, each 1 bit, as datapath controls.
REQ-008 SHALL have outputs ALUSrcB, ALUOp and PCSrc, each 2 bits, as datapath select and control codes.
REQ-009 SHALL have output illegal_op, 1 bit, a one-cycle pulse on an unsupported opcode.
REQ-010 SHALL have output mem_timeout, 1 bit, a one-cycle pulse on a memory wait overrun.
REQ-011 SHALL have output state, 4 bits, the current state for debug.

Function
REQ-012 SHALL implement the states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB and JUMP.
REQ-013 SHALL leave FETCH for DECODE only on mem_ready = 1; otherwise it SHALL hold in FETCH.
REQ-014 SHALL leave DECODE for MEMADR when op = 100011 (lw) or 101011 (sw).
REQ-015 SHALL leave DECODE for EXEC when op = 000000 (R-type).
REQ-016 SHALL leave DECODE for BRANCH when op = 000100 (beq).
REQ-017 SHALL leave DECODE for ADDIEX when op = 001000 (addi).
REQ-018 SHALL leave DECODE for JUMP when op = 000010 (j).
REQ-019 SHALL, on any other op in DECODE, go to FETCH and pulse illegal_op with no register or memory write.
REQ-020 SHALL route MEMADR to MEMRD when op = lw and to MEMWR when op = sw.
REQ-021 SHALL route MEMRD to MEMWB on mem_ready.
REQ-022 SHALL route MEMWR to FETCH on mem_ready.
REQ-023 SHALL route EXEC to ALUWB and ADDIEX to ADDIWB.
REQ-024 SHALL route MEMWB, ALUWB, ADDIWB, BRANCH and JUMP to FETCH unconditionally.
REQ-025 SHALL assert mem_req in FETCH, MEMRD and MEMWR, and keep it asserted until mem_ready.
REQ-026 SHALL assert MemWrite only in MEMWR, held with mem_req.
REQ-027 SHALL qualify IRWrite and PCWrite in FETCH with mem_ready (Mealy); all other outputs SHALL be Moore-decoded from state.
REQ-028 SHALL drive FETCH as IorD 0, ALUSrcA 0, ALUSrcB 01, ALUOp 00, PCSrc 00.
REQ-029 SHALL drive DECODE as ALUSrcA 0, ALUSrcB 11, ALUOp 00.
REQ-030 SHALL drive MEMADR and ADDIEX as ALUSrcA 1, ALUSrcB 10, ALUOp 00.
REQ-031 SHALL drive MEMRD and MEMWR with IorD 1.
REQ-032 SHALL drive MEMWB as RegWrite 1, RegDst 0, MemtoReg 1.
REQ-033 SHALL drive EXEC as ALUSrcA 1, ALUSrcB 00, ALUOp 10.
REQ-034 SHALL drive ALUWB as RegWrite 1, RegDst 1, MemtoReg 0.
REQ-035 SHALL drive ADDIWB as RegWrite 1, RegDst 0, MemtoReg 0.
REQ-036 SHALL drive BRANCH as ALUSrcA 1, ALUSrcB 00, ALUOp 01, PCSrc 01, Branch 1.
REQ-037 SHALL drive JUMP as PCSrc 10, PCWrite 1.
REQ-038 SHALL drive every output not listed for a state to 0.
REQ-039 SHALL run an 8-bit wait counter that clears on entry to each memory state and increments each cycle mem_ready is 0.
REQ-040 SHALL, when the wait counter reaches MEM_WAIT_MAX, pulse mem_timeout, deassert mem_req and go to FETCH with no write.
REQ-041 SHALL ignore mem_ready outside FETCH, MEMRD and MEMWR.
REQ-042 SHALL give latencies with zero-wait memory of lw 5, sw 4, R-type 4, addi 4, beq 3 and j 3 cycles.

Reset
REQ-043 SHALL, while resetn = 0, force state to FETCH and clear the wait counter and the illegal_op/mem_timeout pulses asynchronously; outputs then equal FETCH decode with IRWrite = PCWrite = 0.
REQ-044 SHALL, on reset assertion mid-access, drop MemWrite and RegWrite immediately; no partial write survives.
REQ-045 SHALL release reset synchronously to clk, with the first fetch issued in the first cycle after release.

Structure
REQ-046 SHALL take the opcode constants, state encodings and ALUOp codes from a shared package, also used by the single-cycle decoder and the ALU decoder.
REQ-047 SHALL be a single module with no sub-module; the next-state logic, output decode and wait counter SHALL be separate always blocks.

Verification
REQ-048 SHALL check: lw with mem_ready always 1 -> state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; RegWrite = 1 only in cycle 5, MemtoReg = 1.
REQ-049 SHALL check: sw with mem_ready low 3 cycles in MEMWR -> MemWrite and mem_req high 4 cycles; no RegWrite; return to FETCH.
REQ-050 SHALL check: op = 111111 -> illegal_op high exactly 1 cycle in DECODE, next state FETCH, no write strobes.
REQ-051 SHALL check: beq then j -> PCSrc 01 with Branch 1, then PCSrc 10 with PCWrite 1; 3 cycles each.
REQ-052 SHALL check: MEM_WAIT_MAX = 4 with mem_ready held 0 in FETCH -> mem_timeout pulse after 4 wait cycles, re-fetch follows.
REQ-053 SHALL check: resetn pulled low in MEMWR mid-wait -> MemWrite drops in the same cycle; state = FETCH after release.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared opcode, ALUOp and state definitions for the
// multicycle controller and the companion decoders.
package multicycle_controller_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    function automatic logic is_mem_state(state_t s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

    function automatic logic is_legal_op(logic [5:0] o);
        return (o == OP_RTYPE) || (o == OP_J) ||
               (o == OP_BEQ) || (o == OP_ADDI) ||
               (o == OP_LW) || (o == OP_SW);
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Memory request/completion handshake between the
// controller (master) and the unified memory (slave).
interface multicycle_controller_if;
    import multicycle_controller_pkg::*;

    logic mem_req;
    logic mem_ready;

    modport master (output mem_req, input mem_ready);
    modport slave  (input mem_req, output mem_ready);

endinterface

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control FSM with bounded
// memory waits and illegal-opcode detection.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter logic [7:0] MEM_WAIT_MAX = 8'd255
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       Branch,
    output logic       PCWrite,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state
);

    state_t     cur;
    state_t     nxt;
    logic [7:0] wait_cnt;
    logic       timeout;
    logic       fetch_done;

    assign timeout = is_mem_state(cur) &&
                     (wait_cnt == MEM_WAIT_MAX);
    // resetn gates the Mealy strobes so reset shows pure FETCH decode
    assign fetch_done = mem_ready && !timeout && resetn;
    assign state = cur;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cur <= FETCH;
        else         cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        unique case (cur)
            FETCH: begin
                if (timeout)        nxt = FETCH;
                else if (mem_ready) nxt = DECODE;
            end
            DECODE: begin
                unique case (op)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_RTYPE:     nxt = EXEC;
                    OP_BEQ:       nxt = BRANCH;
                    OP_ADDI:      nxt = ADDIEX;
                    OP_J:         nxt = JUMP;
                    default:      nxt = FETCH;
                endcase
            end
            MEMADR: begin
                if (op == OP_LW)      nxt = MEMRD;
                else if (op == OP_SW) nxt = MEMWR;
                else                  nxt = FETCH;
            end
            MEMRD: begin
                if (timeout)        nxt = FETCH;
                else if (mem_ready) nxt = MEMWB;
            end
            MEMWR: begin
                if (timeout || mem_ready) nxt = FETCH;
            end
            EXEC:    nxt = ALUWB;
            ADDIEX:  nxt = ADDIWB;
            default: nxt = FETCH;
        endcase
    end

    // Any state change (or a timeout re-entry) restarts the count
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            wait_cnt <= 8'd0;
        else if (timeout || (nxt != cur))
            wait_cnt <= 8'd0;
        else if (is_mem_state(cur) && !mem_ready)
            wait_cnt <= wait_cnt + 8'd1;
    end

    always_comb begin
        mem_req     = 1'b0;
        IorD        = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        Branch      = 1'b0;
        PCWrite     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = ALUOP_ADD;
        PCSrc       = 2'b00;
        illegal_op  = 1'b0;
        mem_timeout = timeout;
        unique case (cur)
            FETCH: begin
                mem_req = !timeout;
                ALUSrcB = 2'b01;
                IRWrite = fetch_done;
                PCWrite = fetch_done;
            end
            DECODE: begin
                ALUSrcB    = 2'b11;
                illegal_op = !is_legal_op(op);
            end
            MEMADR, ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMRD: begin
                mem_req = !timeout;
                IorD    = 1'b1;
            end
            MEMWR: begin
                mem_req  = !timeout;
                IorD     = 1'b1;
                MemWrite = !timeout;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            ADDIWB: RegWrite = 1'b1;
            BRANCH: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_SUB;
                PCSrc   = 2'b01;
                Branch  = 1'b1;
            end
            JUMP: begin
                PCSrc   = 2'b10;
                PCWrite = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed and randomized instruction-level checks of
// the multicycle controller against a cycle-plan model.
module tb_multicycle_controller;
    import multicycle_controller_pkg::*;

    localparam int MAXW = 4;

    logic       clk = 1'b0;
    logic       resetn;
    logic [5:0] op;
    logic       IorD, MemWrite, IRWrite, RegDst;
    logic       MemtoReg, RegWrite, ALUSrcA, Branch;
    logic       PCWrite, illegal_op, mem_timeout;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic [3:0] state;

    int checks = 0;
    int failures = 0;
    int n_cyc, n_mw, n_rw, n_ill, n_to;

    multicycle_controller_if mif ();

    multicycle_controller #(.MEM_WAIT_MAX(8'd4)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .op          (op),
        .mem_ready   (mif.mem_ready),
        .mem_req     (mif.mem_req),
        .IorD        (IorD),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .RegDst      (RegDst),
        .MemtoReg    (MemtoReg),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .Branch      (Branch),
        .PCWrite     (PCWrite),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSrc       (PCSrc),
        .illegal_op  (illegal_op),
        .mem_timeout (mem_timeout),
        .state       (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       rdy;
        logic       to;
        logic       ill;
    } step_t;

    step_t plan[$];

    logic [17:0] obs;
    assign obs = {mif.mem_req, IorD, MemWrite, IRWrite,
                  RegDst, MemtoReg, RegWrite, ALUSrcA,
                  Branch, PCWrite, ALUSrcB, ALUOp, PCSrc,
                  illegal_op, mem_timeout};

    // Spec-level per-state output table
    function automatic logic [17:0] exp_out(step_t s);
        logic mreq, iord, mw, irw, rdst, m2r, rw, asa, br, pcw;
        logic [1:0] asb, aop, pcs;
        logic live;
        {mreq, iord, mw, irw, rdst, m2r, rw, asa, br, pcw} = '0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00;
        live = !s.to;
        case (s.st)
            FETCH: begin
                mreq = live; asb = 2'b01;
                irw = s.rdy && live; pcw = s.rdy && live;
            end
            DECODE: asb = 2'b11;
            MEMADR, ADDIEX: begin asa = 1; asb = 2'b10; end
            MEMRD: begin mreq = live; iord = 1; end
            MEMWR: begin mreq = live; iord = 1; mw = live; end
            MEMWB: begin rw = 1; m2r = 1; end
            EXEC: begin asa = 1; aop = 2'b10; end
            ALUWB: begin rw = 1; rdst = 1; end
            ADDIWB: rw = 1;
            BRANCH: begin
                asa = 1; aop = 2'b01; pcs = 2'b01; br = 1;
            end
            JUMP: begin pcs = 2'b10; pcw = 1; end
            default: ;
        endcase
        return {mreq, iord, mw, irw, rdst, m2r, rw, asa,
                br, pcw, asb, aop, pcs, s.ill, s.to};
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h",
                   tag, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] st, input logic rdy,
                        input logic to, input logic ill);
        step_t s;
        s.st = st; s.rdy = rdy; s.to = to; s.ill = ill;
        plan.push_back(s);
    endtask

    // w stall cycles then completion, or timeout after MAXW stalls
    task automatic add_mem(input logic [3:0] st, input int w,
                           output bit tmo);
        if (w >= MAXW) begin
            for (int i = 0; i < MAXW; i++) push(st, 0, 0, 0);
            push(st, 0, 1, 0);
            tmo = 1;
        end else begin
            for (int i = 0; i < w; i++) push(st, 0, 0, 0);
            push(st, 1, 0, 0);
            tmo = 0;
        end
    endtask

    task automatic push_any(input logic [3:0] st,
                            input logic ill);
        push(st, 1'($urandom_range(0, 1)), 0, ill);
    endtask

    task automatic build(input logic [5:0] o,
                         input int wf, input int wm);
        bit t;
        plan.delete();
        add_mem(FETCH, wf, t);
        if (t) add_mem(FETCH, 0, t);
        if (o == OP_LW || o == OP_SW) begin
            push_any(DECODE, 0);
            push_any(MEMADR, 0);
            add_mem(o == OP_LW ? MEMRD : MEMWR, wm, t);
            if (o == OP_LW && !t) push_any(MEMWB, 0);
        end else if (o == OP_RTYPE) begin
            push_any(DECODE, 0);
            push_any(EXEC, 0);
            push_any(ALUWB, 0);
        end else if (o == OP_ADDI) begin
            push_any(DECODE, 0);
            push_any(ADDIEX, 0);
            push_any(ADDIWB, 0);
        end else if (o == OP_BEQ) begin
            push_any(DECODE, 0);
            push_any(BRANCH, 0);
        end else if (o == OP_J) begin
            push_any(DECODE, 0);
            push_any(JUMP, 0);
        end else begin
            push_any(DECODE, 1);
        end
    endtask

    // Entered and left at posedge+1; stop>=0 truncates the plan
    task automatic run(input logic [5:0] o, input int wf,
                       input int wm, input int stop);
        int n;
        step_t s;
        op = o;
        build(o, wf, wm);
        n = (stop >= 0) ? stop : plan.size();
        n_cyc = n; n_mw = 0; n_rw = 0; n_ill = 0; n_to = 0;
        for (int i = 0; i < n; i++) begin
            s = plan[i];
            mif.mem_ready = s.rdy;
            @(negedge clk);
            chk("state", 32'(state), 32'(s.st));
            chk("outputs", 32'(obs), 32'(exp_out(s)));
            n_mw  += int'(MemWrite);
            n_rw  += int'(RegWrite);
            n_ill += int'(illegal_op);
            n_to  += int'(mem_timeout);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit hit");
        $fatal(1, "watchdog");
    end

    initial begin
        step_t r;
        logic [5:0] ops [6];
        logic [5:0] o;
        ops = '{OP_LW, OP_SW, OP_RTYPE, OP_ADDI, OP_BEQ, OP_J};

        resetn = 1'b0;
        op = OP_LW;
        mif.mem_ready = 1'b1;
        @(negedge clk);
        r.st = FETCH; r.rdy = 0; r.to = 0; r.ill = 0;
        chk("rst_state", 32'(state), 32'(FETCH));
        chk("rst_outputs", 32'(obs), 32'(exp_out(r)));
        @(posedge clk);
        #1;
        resetn = 1'b1;

        run(OP_LW, 0, 0, -1);
        chk("lw_cycles", n_cyc, 5);
        chk("lw_regwrite", n_rw, 1);

        run(OP_SW, 0, 3, -1);
        chk("sw_memwrite", n_mw, 4);
        chk("sw_regwrite", n_rw, 0);

        run(6'b111111, 0, 0, -1);
        chk("ill_pulse", n_ill, 1);
        chk("ill_cycles", n_cyc, 2);

        run(OP_BEQ, 0, 0, -1);
        chk("beq_cycles", n_cyc, 3);
        run(OP_J, 0, 0, -1);
        chk("j_cycles", n_cyc, 3);

        run(OP_RTYPE, MAXW, 0, -1);
        chk("fetch_to_pulse", n_to, 1);
        chk("fetch_to_cycles", n_cyc, MAXW + 1 + 1 + 3);

        run(OP_LW, 0, MAXW, -1);
        chk("lw_to_regwrite", n_rw, 0);
        chk("lw_to_pulse", n_to, 1);

        run(OP_SW, 0, 3, 4);
        mif.mem_ready = 1'b0;
        #2;
        chk("pre_rst_memwrite", 32'(MemWrite), 1);
        resetn = 1'b0;
        #1;
        chk("rst_memwrite", 32'(MemWrite), 0);
        chk("rst_regwrite", 32'(RegWrite), 0);
        chk("rst_mid_state", 32'(state), 32'(FETCH));
        @(posedge clk);
        #1;
        resetn = 1'b1;

        run(OP_ADDI, 1, 0, -1);
        chk("addi_cycles", n_cyc, 5);

        for (int k = 0; k < 80; k++) begin
            int idx;
            idx = $urandom_range(0, 6);
            if (idx == 6) o = 6'($urandom);
            else          o = ops[idx];
            run(o, $urandom_range(0, 5),
                $urandom_range(0, 5), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
